// File: rtl/xmoment_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : xmoment_column_sequencer
//  Brief    : Walks a WINDOW_SIZE_Y-row band of a row-major luma frame buffer
//             and emits it one column at a time into the x-moment datapath.
//             Arbitrates the shared read port via request/grant and reports
//             band completion or parameter rejection.
//  Revision : 1.0  initial release
// ============================================================================
module xmoment_column_sequencer #(
    parameter int LUMA_BITS     = 8,
    parameter int WINDOW_SIZE_X = 7,
    parameter int WINDOW_SIZE_Y = 5,
    parameter int MAX_WIDTH     = 1024,
    parameter int MAX_HEIGHT    = 1024,
    localparam int XW        = $clog2(MAX_WIDTH + 1),
    localparam int YW        = $clog2(MAX_HEIGHT + 1),
    localparam int ADDR_BITS = $clog2(MAX_WIDTH * MAX_HEIGHT)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_start,
    input  logic [XW-1:0]                      in_width,
    input  logic [YW-1:0]                      in_height,
    input  logic [YW-1:0]                      in_row_top,
    output logic                               mem_rd_en,
    output logic [ADDR_BITS-1:0]               mem_addr,
    input  logic                               mem_rd_gnt,
    input  logic [LUMA_BITS-1:0]               mem_rd_data,
    output logic                               col_valid,
    output logic                               col_reset,
    output logic [LUMA_BITS*WINDOW_SIZE_Y-1:0] col_data,
    output logic [XW-1:0]                      col_x,
    output logic                               out_busy,
    output logic                               out_done,
    output logic                               out_error
);

    localparam int RW = (WINDOW_SIZE_Y > 1) ? $clog2(WINDOW_SIZE_Y) : 1;
    localparam int CW = LUMA_BITS * WINDOW_SIZE_Y;

    localparam logic [XW-1:0] c_min_width = XW'(WINDOW_SIZE_X);
    localparam logic [XW-1:0] c_max_width = XW'(MAX_WIDTH);
    localparam logic [YW:0]   c_rows      = (YW+1)'(WINDOW_SIZE_Y);
    localparam logic [RW-1:0] c_last_row  = RW'(WINDOW_SIZE_Y - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [XW-1:0]          r_width;
    logic [YW-1:0]          r_height;
    logic [YW-1:0]          r_row_top;
    logic [XW-1:0]          r_x;
    logic [RW-1:0]          r_row;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   r_col_base;
    logic                   r_rd_en;
    logic                   r_cap_valid;
    logic [RW-1:0]          r_cap_idx;
    logic [CW-1:0]          r_slots;
    logic [CW-1:0]          r_col_data;
    logic                   r_col_valid;
    logic                   r_col_reset;
    logic [XW-1:0]          r_col_x;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic                   w_reject;
    logic                   w_last_col;
    logic [ADDR_BITS-1:0]   w_width_a;
    logic [ADDR_BITS-1:0]   w_origin;
    logic [CW-1:0]          w_slots_next;

    // Band parameter screening; the row sum is one bit wider so it cannot wrap
    assign w_reject   = (r_width < c_min_width) || (r_width > c_max_width) ||
                        (({1'b0, r_row_top} + c_rows) > {1'b0, r_height});
    assign w_last_col = (r_x == (r_width - XW'(1)));
    assign w_width_a  = ADDR_BITS'(r_width);
    // Band origin row_top*width, formed once per band; every later address
    // is reached by adding width (next row) or one (next column)
    assign w_origin   = ADDR_BITS'(r_row_top) * w_width_a;

    // Slot array with the pending read data merged in (data lags grant by one)
    always_comb begin
        w_slots_next = r_slots;
        if (r_cap_valid) begin
            w_slots_next[r_cap_idx*LUMA_BITS +: LUMA_BITS] = mem_rd_data;
        end
    end

    // Sequencer FSM with registered outputs; async reset aborts a band at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_row_top   <= '0;
            r_x         <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_col_base  <= '0;
            r_rd_en     <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_slots     <= '0;
            r_col_data  <= '0;
            r_col_valid <= 1'b0;
            r_col_reset <= 1'b0;
            r_col_x     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_slots     <= w_slots_next;
            r_cap_valid <= 1'b0;
            r_col_valid <= 1'b0;
            r_col_reset <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_width   <= in_width;
                        r_height  <= in_height;
                        r_row_top <= in_row_top;
                        r_x       <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr     <= w_origin;
                        r_col_base <= w_origin;
                        r_row      <= '0;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Address and request stay put until the grant arrives
                    if (mem_rd_gnt) begin
                        r_cap_valid <= 1'b1;
                        r_cap_idx   <= r_row;
                        if (r_row == c_last_row) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_WAIT;
                        end else begin
                            r_row  <= r_row + RW'(1);
                            r_addr <= r_addr + w_width_a;
                        end
                    end
                end
                S_WAIT: begin
                    // Last row lands this cycle; publish the whole column
                    r_col_data  <= w_slots_next;
                    r_col_valid <= 1'b1;
                    r_col_reset <= (r_x == '0);
                    r_col_x     <= r_x;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    r_x <= r_x + XW'(1);
                    if (w_last_col) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_col_base <= r_col_base + ADDR_BITS'(1);
                        r_addr     <= r_col_base + ADDR_BITS'(1);
                        r_row      <= '0;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_addr;
    assign col_valid = r_col_valid;
    assign col_reset = r_col_reset;
    assign col_data  = r_col_data;
    assign col_x     = r_col_x;
    assign out_busy  = r_busy;
    assign out_done  = r_done;
    assign out_error = r_error;

endmodule
`default_nettype wire
